// File: rtl/greenhouse_zone_ctrl.sv
// Per-zone climate controller: debounce a 2-bit thermostat code, then drive
// heater/cooler with a minimum run time and a sticky inconsistency fault.
module greenhouse_zone_ctrl #(
    parameter int NZONES  = 4,
    parameter int FILT    = 3,
    parameter int MIN_RUN = 8,
    parameter int FCNT_W  = 4
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic [2*NZONES-1:0]   sens,
    input  logic                  fault_clr,
    output logic [NZONES-1:0]     heater,
    output logic [NZONES-1:0]     cooler,
    output logic [NZONES-1:0]     fault,
    output logic                  fault_any,
    output logic [FCNT_W-1:0]     fault_count
);

    localparam int CNT_W = $clog2(FILT + 1);
    localparam int RUN_W = $clog2(MIN_RUN + 1);

    localparam logic [1:0] CODE_COLD = 2'b00;
    localparam logic [1:0] CODE_BAD  = 2'b01;
    localparam logic [1:0] CODE_BAND = 2'b10;
    localparam logic [1:0] CODE_HOT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HEAT  = 2'd1,
        ST_COOL  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    logic [NZONES-1:0]  w_fault_entry;
    logic [FCNT_W-1:0]  r_fault_count;

    genvar gi;
    generate
        for (gi = 0; gi < NZONES; gi++) begin : g_zone
            logic [1:0]       w_raw;
            logic [1:0]       r_cand;
            logic [1:0]       r_filt;
            logic [CNT_W-1:0] r_cnt;
            state_t           r_state;
            state_t           w_state_next;
            logic [RUN_W-1:0] r_run_cnt;
            logic [RUN_W-1:0] w_run_cnt_next;

            assign w_raw = sens[2*gi +: 2];

            // filt only moves once the same raw code has been seen FILT edges running
            always_ff @(posedge clk_2) begin
                if (reset) begin
                    r_cand <= CODE_BAND;
                    r_filt <= CODE_BAND;
                    r_cnt  <= '0;
                end else if (w_raw != r_cand) begin
                    r_cand <= w_raw;
                    r_cnt  <= CNT_W'(1);
                end else if (r_cnt < CNT_W'(FILT - 1)) begin
                    r_cnt  <= r_cnt + 1'b1;
                end else begin
                    r_filt <= r_cand;
                end
            end

            always_ff @(posedge clk_2) begin
                if (reset) begin
                    r_state   <= ST_IDLE;
                    r_run_cnt <= '0;
                end else begin
                    r_state   <= w_state_next;
                    r_run_cnt <= w_run_cnt_next;
                end
            end

            always_comb begin
                w_state_next = r_state;
                case (r_state)
                    ST_IDLE: begin
                        case (r_filt)
                            CODE_COLD: w_state_next = ST_HEAT;
                            CODE_HOT:  w_state_next = ST_COOL;
                            CODE_BAD:  w_state_next = ST_FAULT;
                            default:   w_state_next = ST_IDLE;
                        endcase
                    end
                    ST_HEAT: begin
                        if (r_filt == CODE_BAD)
                            w_state_next = ST_FAULT;
                        else if (r_filt != CODE_COLD && r_run_cnt == RUN_W'(MIN_RUN))
                            w_state_next = ST_IDLE;
                    end
                    ST_COOL: begin
                        if (r_filt == CODE_BAD)
                            w_state_next = ST_FAULT;
                        else if (r_filt != CODE_HOT && r_run_cnt == RUN_W'(MIN_RUN))
                            w_state_next = ST_IDLE;
                    end
                    ST_FAULT: begin
                        if (fault_clr && r_filt != CODE_BAD)
                            w_state_next = ST_IDLE;
                    end
                    default: w_state_next = ST_IDLE;
                endcase
            end

            // run counter is zero on the entry edge and counts only while staying put
            always_comb begin
                w_run_cnt_next = '0;
                if ((r_state == ST_HEAT || r_state == ST_COOL) && w_state_next == r_state) begin
                    if (r_run_cnt == RUN_W'(MIN_RUN))
                        w_run_cnt_next = r_run_cnt;
                    else
                        w_run_cnt_next = r_run_cnt + 1'b1;
                end
            end

            assign heater[gi]        = (r_state == ST_HEAT);
            assign cooler[gi]        = (r_state == ST_COOL);
            assign fault[gi]         = (r_state == ST_FAULT);
            assign w_fault_entry[gi] = (r_state != ST_FAULT) && (w_state_next == ST_FAULT);
        end
    endgenerate

    // simultaneous entries in several zones count as a single event
    always_ff @(posedge clk_2) begin
        if (reset)
            r_fault_count <= '0;
        else if (|w_fault_entry && r_fault_count != '1)
            r_fault_count <= r_fault_count + 1'b1;
    end

    assign fault_count = r_fault_count;
    assign fault_any   = |fault;

endmodule

// File: tb/tb_greenhouse_zone_ctrl.sv
// Directed bench for greenhouse_zone_ctrl: a stimulus process queues expected
// outputs per edge and a monitor on the falling edge pops and compares them.
module tb_greenhouse_zone_ctrl;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sens = 8'hAA;
    logic       fault_clr = 1'b0;
    logic [3:0] heater;
    logic [3:0] cooler;
    logic [3:0] fault;
    logic       fault_any;
    logic [3:0] fault_count;

    greenhouse_zone_ctrl #(
        .NZONES(4), .FILT(3), .MIN_RUN(8), .FCNT_W(4)
    ) dut (
        .clk_2(clk_2),
        .reset(reset),
        .sens(sens),
        .fault_clr(fault_clr),
        .heater(heater),
        .cooler(cooler),
        .fault(fault),
        .fault_any(fault_any),
        .fault_count(fault_count)
    );

    always #5 clk_2 = ~clk_2;

    int cyc = 0;
    always @(posedge clk_2) cyc <= cyc + 1;

    typedef struct packed {
        int         at;
        logic [3:0] h;
        logic [3:0] c;
        logic [3:0] f;
        logic       fa;
        logic [3:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    // Drive one edge's inputs and queue the outputs expected after that edge
    task automatic step(input logic [7:0] s, input logic clr, input logic rst,
                        input logic [3:0] eh, input logic [3:0] ec, input logic [3:0] ef,
                        input logic [3:0] ecnt, input string nm);
        exp_t e;
        @(posedge clk_2);
        #1;
        sens      = s;
        fault_clr = clr;
        reset     = rst;
        e.at  = cyc + 1;
        e.h   = eh;
        e.c   = ec;
        e.f   = ef;
        e.fa  = |ef;
        e.cnt = ecnt;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk_2);
            if (cyc > 1) begin
                checks++;
                if ((heater & cooler) != 4'b0000) begin
                    errors++;
                    $display("FAIL exclusive cyc=%0d heater=%b cooler=%b required no overlap",
                             cyc, heater, cooler);
                end
            end
            while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (e.at != cyc || heater !== e.h || cooler !== e.c || fault !== e.f ||
                    fault_any !== e.fa || fault_count !== e.cnt) begin
                    errors++;
                    $display("FAIL %0s cyc=%0d (due %0d) got h=%b c=%b f=%b any=%b cnt=%0d required h=%b c=%b f=%b any=%b cnt=%0d",
                             nm, cyc, e.at, heater, cooler, fault, fault_any, fault_count,
                             e.h, e.c, e.f, e.fa, e.cnt);
                end else begin
                    $display("chk %0s cyc=%0d h=%b c=%b f=%b any=%b cnt=%0d",
                             nm, cyc, heater, cooler, fault, fault_any, fault_count);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: stimulus did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int prev_cnt;
        int next_cnt;

        // reset state
        step(8'hAA, 0, 1, 4'h0, 4'h0, 4'h0, 4'd0, "reset");
        step(8'hAA, 0, 1, 4'h0, 4'h0, 4'h0, 4'd0, "reset_hold");

        // zone0 cold: heater after 4th edge, held 9 cycles, code back in band after 2
        for (int i = 1; i <= 13; i++)
            step((i <= 6) ? 8'hA8 : 8'hAA, 0, 0,
                 (i >= 4 && i <= 12) ? 4'b0001 : 4'b0000, 4'h0, 4'h0, 4'd0, "heat_min_run");

        // zone1 hot for only two samples: must be filtered out
        for (int i = 1; i <= 6; i++)
            step((i <= 2) ? 8'hAE : 8'hAA, 0, 0, 4'h0, 4'h0, 4'h0, 4'd0, "glitch");

        // zone2 cool, then inconsistent code, clear attempts, then clear
        for (int i = 1; i <= 5; i++)
            step(8'hBA, 0, 0, 4'h0, (i >= 4) ? 4'b0100 : 4'b0000, 4'h0, 4'd0, "cool_entry");
        for (int i = 1; i <= 3; i++)
            step(8'h9A, 0, 0, 4'h0, 4'b0100, 4'h0, 4'd0, "cool_bad_filter");
        step(8'h9A, 0, 0, 4'h0, 4'h0, 4'b0100, 4'd1, "fault_entry");
        step(8'h9A, 1, 0, 4'h0, 4'h0, 4'b0100, 4'd1, "clr_while_bad");
        step(8'hAA, 0, 0, 4'h0, 4'h0, 4'b0100, 4'd1, "fault_hold");
        step(8'hAA, 1, 0, 4'h0, 4'h0, 4'b0100, 4'd1, "clr_before_filt");
        step(8'hAA, 0, 0, 4'h0, 4'h0, 4'b0100, 4'd1, "fault_hold2");
        step(8'hAA, 1, 0, 4'h0, 4'h0, 4'h0,    4'd1, "fault_clear");
        step(8'hAA, 0, 0, 4'h0, 4'h0, 4'h0,    4'd1, "after_clear");

        // zones 0 and 3 fault together repeatedly: one count per event, saturate at 15
        for (int i = 0; i < 15; i++) begin
            prev_cnt = (1 + i > 15) ? 15 : 1 + i;
            next_cnt = (2 + i > 15) ? 15 : 2 + i;
            for (int j = 0; j < 3; j++)
                step(8'h69, 0, 0, 4'h0, 4'h0, 4'h0, 4'(prev_cnt), "cnt_filter");
            step(8'h69, 1, 0, 4'h0, 4'h0, 4'b1001, 4'(next_cnt), "cnt_entry");
            for (int j = 0; j < 3; j++)
                step(8'hAA, 0, 0, 4'h0, 4'h0, 4'b1001, 4'(next_cnt), "cnt_fault_hold");
            step(8'hAA, 1, 0, 4'h0, 4'h0, 4'h0, 4'(next_cnt), "cnt_clear");
        end

        // mid-operation reset with zone0 heating and zone1 faulted
        for (int i = 1; i <= 3; i++)
            step(8'hA4, 0, 0, 4'h0, 4'h0, 4'h0, 4'd15, "mix_filter");
        step(8'hA4, 0, 0, 4'b0001, 4'h0, 4'b0010, 4'd15, "mix_active");
        step(8'hA4, 0, 0, 4'b0001, 4'h0, 4'b0010, 4'd15, "mix_hold");
        step(8'hA4, 0, 1, 4'h0, 4'h0, 4'h0, 4'd0, "mid_reset");
        for (int i = 1; i <= 3; i++)
            step(8'hA4, 0, 0, 4'h0, 4'h0, 4'h0, 4'd0, "post_reset_filter");
        step(8'hA4, 0, 0, 4'b0001, 4'h0, 4'b0010, 4'd1, "post_reset_active");

        repeat (3) @(posedge clk_2);
        @(negedge clk_2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/greenhouse_zone_ctrl.md
GREENHOUSE_ZONE_CTRL -- requirements
Module: greenhouse_zone_ctrl

Interface
REQ-001 The block SHALL have parameter NZONES, default 4, giving the number of independent climate zones (1..8).
REQ-002 The block SHALL have parameter FILT, default 3, giving the consecutive-sample count needed to accept a sensor code (>=2).
REQ-003 The block SHALL have parameter MIN_RUN, default 8, giving the minimum actuator run length in cycles (>=1).
REQ-004 The block SHALL have parameter FCNT_W, default 4, giving the fault event counter width.
REQ-005 The block SHALL have port clk_2, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port sens, input, 2*NZONES bits: zone z code = {sens[2z+1], sens[2z]}; 00 = cold, 11 = hot, 10 = in band, 01 = inconsistent.
REQ-008 The block SHALL have port fault_clr, input, 1 bit: request to clear sticky zone faults.
REQ-009 The block SHALL have port heater, output, NZONES bits: heater on per zone.
REQ-010 The block SHALL have port cooler, output, NZONES bits: cooler on per zone.
REQ-011 The block SHALL have port fault, output, NZONES bits: sticky inconsistency flag per zone.
REQ-012 The block SHALL have port fault_any, output, 1 bit: OR of fault.
REQ-013 The block SHALL have port fault_count, output, FCNT_W bits: saturating count of fault events.

Function
REQ-014 The block SHALL give each zone a filter holding cand (2b), cnt and filt (2b).
REQ-015 Filter update rule: if raw != cand, then cand<=raw and cnt<=1; else if cnt < FILT-1, cnt increments; else filt<=cand and cnt holds.
REQ-016 filt SHALL therefore change on the FILT-th consecutive rising edge that samples the same raw code; any shorter pulse SHALL be discarded.
REQ-017 The block SHALL give each zone an FSM with states IDLE, HEAT, COOL and FAULT, plus a run counter run_cnt that saturates at MIN_RUN.
REQ-018 IDLE transitions: filt=00 goes to HEAT, filt=11 goes to COOL, filt=01 goes to FAULT, and filt=10 stays in IDLE.
REQ-019 HEAT and COOL transitions: run_cnt clears on entry and increments each cycle while in the state; the FSM leaves to IDLE only when filt no longer matches and run_cnt==MIN_RUN.
REQ-020 HEAT SHALL never transition directly to COOL, and COOL SHALL never transition directly to HEAT; the path always passes through IDLE.
REQ-021 filt=01 in HEAT or COOL SHALL force FAULT on the next edge, regardless of run_cnt.
REQ-022 FAULT SHALL exit to IDLE only on an edge where fault_clr=1 and filt!=01; fault_clr while filt=01 SHALL be ignored.
REQ-023 Outputs SHALL be registered state decodes: heater[z]=(HEAT), cooler[z]=(COOL), fault[z]=(FAULT); heater and cooler SHALL never both be 1 in a zone.
REQ-024 Latency: from the first edge sampling a new stable code to the output change SHALL be FILT+1 cycles.
REQ-025 Once entered, heater or cooler SHALL stay high for at least MIN_RUN+1 cycles unless a fault occurs.
REQ-026 fault_count SHALL increment by 1 on each edge where at least one zone enters FAULT, with several simultaneous entries counting once.
REQ-027 fault_count SHALL saturate at all-ones and SHALL clear only on reset.
REQ-028 If fault_clr coincides with a zone's FAULT entry edge, the entry SHALL take precedence.
REQ-029 Zones SHALL be fully independent except for fault_any and fault_count.

Reset
REQ-030 While reset=1 at an edge, every zone SHALL go to IDLE with run_cnt=0, cand=10, filt=10 and cnt=0, and fault_count SHALL be 0.
REQ-031 All outputs SHALL be 0 from the edge after reset is asserted.
REQ-032 Reset asserted mid-operation (HEAT, COOL or FAULT) SHALL take effect at the next edge and override all other inputs.

Verification (NZONES=4, FILT=3, MIN_RUN=8, FCNT_W=4)
REQ-033 Heat entry: reset, then zone0 code 00 held -> heater[0]=1 after the 4th edge; cooler=0 and fault=0 throughout.
REQ-034 Glitch rejection: zone1 code 11 for 2 cycles, then 10 -> cooler[1] stays 0 throughout.
REQ-035 Minimum run: zone0 in HEAT, code returns to 10 after 2 cycles -> heater[0] stays high for 9 cycles after entry, then drops.
REQ-036 Fault handling: zone2 in COOL, code 01 stable for 3 edges -> cooler[2]=0, fault[2]=1, fault_any=1, fault_count=1; fault_clr pulsed while code is 01 -> no change; after code 10 is filtered, fault_clr pulsed -> fault[2]=0.
REQ-037 Counter: zones 0 and 3 enter FAULT on the same edge -> fault_count increases by 1; after 15 or more events, fault_count=15 and holds.
REQ-038 Mid-operation reset: reset pulsed while zone0 is in HEAT and zone1 is in FAULT -> all outputs 0 on the next edge, and heater needs FILT+1 edges after reset release to reassert.
